// File: rtl/divider_pkg.sv
// Shared types and elaboration helpers for the pipelined restoring divider.
package divider_pkg;

  // Per-stage control bits. The data fields (partial remainder, quotient/dividend
  // shift word, |divisor|, tag) depend on instance parameters, so they are carried
  // beside this struct as separate vectors.
  typedef struct packed {
    logic valid;
    logic q_neg;
    logic r_neg;
    logic dbz;
    logic ovf;
  } stage_flags_t;

  function automatic int calc_latency(input int dividend_w, input int bits_per_stage);
    return dividend_w / bits_per_stage + 2;
  endfunction

  function automatic bit params_legal(input int dividend_w, input int divisor_w,
                                      input int bits_per_stage);
    return ((bits_per_stage == 1) || (bits_per_stage == 2) || (bits_per_stage == 4)) &&
           (dividend_w % bits_per_stage == 0) && (divisor_w >= 1) &&
           (dividend_w >= 2) && (divisor_w <= dividend_w);
  endfunction

endpackage

// File: rtl/div_stage.sv
// One restoring-division stage: resolves BITS_PER_STAGE quotient bits, then registers.
module div_stage
  import divider_pkg::*;
#(
  parameter int DIVIDEND_W     = 32,
  parameter int DIVISOR_W      = 24,
  parameter int BITS_PER_STAGE = 1,
  parameter int TAG_W          = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  i_advance,
  input  stage_flags_t          i_flags,
  input  logic [TAG_W-1:0]      i_tag,
  input  logic [DIVISOR_W-1:0]  i_partial,
  input  logic [DIVIDEND_W-1:0] i_qd,
  input  logic [DIVISOR_W-1:0]  i_dvsr,
  output stage_flags_t          o_flags,
  output logic [TAG_W-1:0]      o_tag,
  output logic [DIVISOR_W-1:0]  o_partial,
  output logic [DIVIDEND_W-1:0] o_qd,
  output logic [DIVISOR_W-1:0]  o_dvsr
);

  logic [DIVISOR_W:0]    w_trial;
  logic [DIVISOR_W-1:0]  w_partial;
  logic [DIVIDEND_W-1:0] w_qd;

  stage_flags_t          r_flags;
  logic [TAG_W-1:0]      r_tag;
  logic [DIVISOR_W-1:0]  r_partial;
  logic [DIVIDEND_W-1:0] r_qd;
  logic [DIVISOR_W-1:0]  r_dvsr;

  // qd holds unconsumed dividend bits at the top and resolved quotient bits at the bottom.
  always_comb begin
    w_partial = i_partial;
    w_qd      = i_qd;
    w_trial   = '0;
    for (int b = 0; b < BITS_PER_STAGE; b++) begin
      w_trial = {w_partial, w_qd[DIVIDEND_W-1]};
      w_qd    = {w_qd[DIVIDEND_W-2:0], 1'b0};
      if (w_trial >= {1'b0, i_dvsr}) begin
        w_trial = w_trial - {1'b0, i_dvsr};
        w_qd[0] = 1'b1;
      end
      w_partial = w_trial[DIVISOR_W-1:0];
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_flags <= '0;
    end else if (i_advance) begin
      r_flags <= i_flags;
    end
  end

  always_ff @(posedge clock) begin
    if (i_advance) begin
      r_tag     <= i_tag;
      r_partial <= w_partial;
      r_qd      <= w_qd;
      r_dvsr    <= i_dvsr;
    end
  end

  assign o_flags   = r_flags;
  assign o_tag     = r_tag;
  assign o_partial = r_partial;
  assign o_qd      = r_qd;
  assign o_dvsr    = r_dvsr;

endmodule

// File: rtl/pipelined_divider.sv
// Fully pipelined signed/unsigned integer divider with truncating semantics.
// Handshake: a stage moves only when advance = ~ovalid | oready; iready = advance, and an
// input transfers when ivalid & iready; a result transfers when ovalid & oready.
module pipelined_divider
  import divider_pkg::*;
#(
  parameter int DIVIDEND_W     = 32,
  parameter int DIVISOR_W      = 24,
  parameter int BITS_PER_STAGE = 1,
  parameter int TAG_W          = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  ivalid,
  output logic                  iready,
  input  logic                  is_signed,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  input  logic [TAG_W-1:0]      itag,
  output logic                  ovalid,
  input  logic                  oready,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  div_by_zero,
  output logic                  overflow,
  output logic [TAG_W-1:0]      otag
);

  localparam int STAGES = DIVIDEND_W / BITS_PER_STAGE;
  localparam logic [DIVIDEND_W-1:0] MIN_DIVIDEND = {1'b1, {(DIVIDEND_W-1){1'b0}}};

  if (!params_legal(DIVIDEND_W, DIVISOR_W, BITS_PER_STAGE)) begin : g_bad_params
    $error("pipelined_divider: illegal DIVIDEND_W/DIVISOR_W/BITS_PER_STAGE combination");
  end

  logic                  w_advance;
  logic                  w_dd_neg;
  logic                  w_dv_neg;
  logic [DIVIDEND_W-1:0] w_dd_abs;
  logic [DIVISOR_W-1:0]  w_dv_abs;

  stage_flags_t          r_in_flags;
  logic [TAG_W-1:0]      r_in_tag;
  logic [DIVIDEND_W-1:0] r_in_qd;
  logic [DIVISOR_W-1:0]  r_in_dvsr;

  stage_flags_t          w_flags   [0:STAGES];
  logic [TAG_W-1:0]      w_tag     [0:STAGES];
  logic [DIVISOR_W-1:0]  w_partial [0:STAGES];
  logic [DIVIDEND_W-1:0] w_qd      [0:STAGES];
  logic [DIVISOR_W-1:0]  w_dvsr    [0:STAGES];

  logic                  r_ovalid;
  logic [DIVIDEND_W-1:0] r_quotient;
  logic [DIVISOR_W-1:0]  r_remainder;
  logic                  r_dbz;
  logic                  r_ovf;
  logic [TAG_W-1:0]      r_otag;

  assign w_advance = ~r_ovalid | oready;
  assign iready    = w_advance;

  assign w_dd_neg = is_signed & dividend[DIVIDEND_W-1];
  assign w_dv_neg = is_signed & divisor[DIVISOR_W-1];
  assign w_dd_abs = w_dd_neg ? -dividend : dividend;
  assign w_dv_abs = w_dv_neg ? -divisor : divisor;

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_in_flags <= '0;
    end else if (w_advance) begin
      r_in_flags.valid <= ivalid;
      r_in_flags.q_neg <= w_dd_neg ^ w_dv_neg;
      r_in_flags.r_neg <= w_dd_neg;
      r_in_flags.dbz   <= (divisor == '0);
      r_in_flags.ovf   <= is_signed & (dividend == MIN_DIVIDEND) & (&divisor);
    end
  end

  always_ff @(posedge clock) begin
    if (w_advance) begin
      r_in_tag  <= itag;
      r_in_qd   <= w_dd_abs;
      r_in_dvsr <= w_dv_abs;
    end
  end

  assign w_flags[0]   = r_in_flags;
  assign w_tag[0]     = r_in_tag;
  assign w_partial[0] = '0;
  assign w_qd[0]      = r_in_qd;
  assign w_dvsr[0]    = r_in_dvsr;

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    div_stage #(
      .DIVIDEND_W    (DIVIDEND_W),
      .DIVISOR_W     (DIVISOR_W),
      .BITS_PER_STAGE(BITS_PER_STAGE),
      .TAG_W         (TAG_W)
    ) u_stage (
      .clock    (clock),
      .reset    (reset),
      .i_advance(w_advance),
      .i_flags  (w_flags[i]),
      .i_tag    (w_tag[i]),
      .i_partial(w_partial[i]),
      .i_qd     (w_qd[i]),
      .i_dvsr   (w_dvsr[i]),
      .o_flags  (w_flags[i+1]),
      .o_tag    (w_tag[i+1]),
      .o_partial(w_partial[i+1]),
      .o_qd     (w_qd[i+1]),
      .o_dvsr   (w_dvsr[i+1])
    );
  end

  // Output stage: bubbles leave the previous data in place and only drop ovalid.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_ovalid    <= 1'b0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_dbz       <= 1'b0;
      r_ovf       <= 1'b0;
      r_otag      <= '0;
    end else if (w_advance) begin
      r_ovalid <= w_flags[STAGES].valid;
      if (w_flags[STAGES].valid) begin
        r_otag <= w_tag[STAGES];
        r_dbz  <= w_flags[STAGES].dbz;
        r_ovf  <= w_flags[STAGES].ovf & ~w_flags[STAGES].dbz;
        if (w_flags[STAGES].dbz) begin
          r_quotient  <= '1;
          r_remainder <= '0;
        end else if (w_flags[STAGES].ovf) begin
          r_quotient  <= MIN_DIVIDEND;
          r_remainder <= '0;
        end else begin
          r_quotient  <= w_flags[STAGES].q_neg ? -w_qd[STAGES] : w_qd[STAGES];
          r_remainder <= w_flags[STAGES].r_neg ? -w_partial[STAGES] : w_partial[STAGES];
        end
      end
    end
  end

  assign ovalid      = r_ovalid;
  assign quotient    = r_quotient;
  assign remainder   = r_remainder;
  assign div_by_zero = r_dbz;
  assign overflow    = r_ovf;
  assign otag        = r_otag;

endmodule
